// File: rtl/rf_pkg.sv
// Shared register-file definitions for the RV32I core.
//   REG_W   - register address width
//   DATA_W  - register data width
//   REG_S   - number of architectural registers
//   wb_req_t    - writeback request {rd, wd}
//   arb_state_e - writeback arbiter priority state
// Used by the register file, the writeback stage and the write-port arbiter.
package rf_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_S  = 1 << REG_W;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] wd;
    } wb_req_t;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_wb_prio_fsm.sv
// Priority FSM for the register-file write-port arbiter.
// Port 0 normally has priority; after STARVE_MAX consecutive stalled cycles of
// port 1 the FSM spends one cycle in PRI1 so port 1 is granted.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   s0_valid, s1_valid  - write requests from port 0 (ALU) and port 1 (load unit)
//   s0_ready, s1_ready  - combinational grants
//   starve              - high while in PRI1
module rf_wb_prio_fsm
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic s0_valid,
    input  logic s1_valid,
    output logic s0_ready,
    output logic s1_ready,
    output logic starve
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s0_ready = 1'b1;
        s1_ready = 1'b1;

        unique case (state_q)
            PRI0: begin
                s0_ready = 1'b1;
                s1_ready = !s0_valid;
            end
            PRI1: begin
                s1_ready = 1'b1;
                s0_ready = !s1_valid;
            end
            default: ;
        endcase

        stall = s1_valid && !s1_ready;

        if (!stall) begin
            // Port-1 handshake or no port-1 request: the wait is over.
            cnt_d = '0;
        end else if (state_q == PRI0 && cnt_q == CNT_LAST) begin
            state_d = PRI1;
            cnt_d   = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Leave PRI1 on the port-1 handshake, or if the request was withdrawn.
        if (state_q == PRI1 && (!s1_valid || s1_ready)) begin
            state_d = PRI0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRI0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign starve = (state_q == PRI1);

endmodule

// File: rtl/rf_wb_arb.sv
// Write-port arbiter for the 32x32 RV32I register file.
// Shares the single register-file write port between port 0 (ALU) and port 1
// (load/multicycle unit). Port 0 has fixed priority; port 1 is force-granted
// after STARVE_MAX stalled cycles. The granted write is registered and drives
// the register file's a3/wd/we directly. Writes to x0 are accepted but never
// raise rf_we.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   s0_valid/s0_rd/s0_wd/s0_ready - ALU writeback request
//   s1_valid/s1_rd/s1_wd/s1_ready - load-unit writeback request
//   rf_we/rf_a3/rf_wd           - register-file write port
//   starve_o                    - high while port 1 has forced priority
// Optional (macro RF_WB_FWD_EN):
//   fwd_a1/fwd_a2, rf_rd1/rf_rd2 in; fwd_rd1/fwd_rd2 out - bypass of the
//   pending write to same-cycle register-file readers.
module rf_wb_arb #(
    parameter int unsigned REG_W      = rf_pkg::REG_W,
    parameter int unsigned DATA_W     = rf_pkg::DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    input  logic [REG_W-1:0]  s0_rd,
    input  logic [DATA_W-1:0] s0_wd,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [REG_W-1:0]  s1_rd,
    input  logic [DATA_W-1:0] s1_wd,
    output logic              s1_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_a3,
    output logic [DATA_W-1:0] rf_wd,
    output logic              starve_o
`ifdef RF_WB_FWD_EN
    ,
    input  logic [REG_W-1:0]  fwd_a1,
    input  logic [REG_W-1:0]  fwd_a2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [DATA_W-1:0] fwd_rd1,
    output logic [DATA_W-1:0] fwd_rd2
`endif
);

    logic s0_fire;
    logic s1_fire;

    rf_wb_prio_fsm #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_fsm (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s1_valid (s1_valid),
        .s0_ready (s0_ready),
        .s1_ready (s1_ready),
        .starve   (starve_o)
    );

    // The FSM never readies both ports while both are valid, so at most one fires.
    assign s0_fire = s0_valid && s0_ready;
    assign s1_fire = s1_valid && s1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else if (s0_fire) begin
            rf_we <= (s0_rd != '0);
            rf_a3 <= s0_rd;
            rf_wd <= s0_wd;
        end else if (s1_fire) begin
            rf_we <= (s1_rd != '0);
            rf_a3 <= s1_rd;
            rf_wd <= s1_wd;
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef RF_WB_FWD_EN
    // Readers in the write cycle see the value the register file is about to commit.
    always_comb begin
        fwd_rd1 = rf_rd1;
        fwd_rd2 = rf_rd2;
        if (rf_we && rf_a3 == fwd_a1 && fwd_a1 != '0) begin
            fwd_rd1 = rf_wd;
        end
        if (rf_we && rf_a3 == fwd_a2 && fwd_a2 != '0) begin
            fwd_rd2 = rf_wd;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb. A behavioural model tracks how many
// consecutive cycles port 1 has been refused; port 1 wins once that reaches
// STARVE_MAX, otherwise port 0 wins whenever it is valid.
module tb_rf_wb_arb;

    localparam int unsigned SM = 4;

    logic        clk;
    logic        rst;
    logic        s0_valid;
    logic [4:0]  s0_rd;
    logic [31:0] s0_wd;
    logic        s0_ready;
    logic        s1_valid;
    logic [4:0]  s1_rd;
    logic [31:0] s1_wd;
    logic        s1_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        starve_o;
`ifdef RF_WB_FWD_EN
    logic [4:0]  fwd_a1;
    logic [4:0]  fwd_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] fwd_rd1;
    logic [31:0] fwd_rd2;
`endif

    int n_cmp;
    int n_err;

    // Reference model state.
    int          refused;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic        last_g0;
    logic        last_g1;

    // Register file fed by the arbiter outputs.
    logic [31:0] rfile [32];

    rf_wb_arb #(
        .REG_W      (5),
        .DATA_W     (32),
        .STARVE_MAX (SM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_rd    (s0_rd),
        .s0_wd    (s0_wd),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_rd    (s1_rd),
        .s1_wd    (s1_wd),
        .s1_ready (s1_ready),
        .rf_we    (rf_we),
        .rf_a3    (rf_a3),
        .rf_wd    (rf_wd),
        .starve_o (starve_o)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_a1   (fwd_a1),
        .fwd_a2   (fwd_a2),
        .rf_rd1   (rf_rd1),
        .rf_rd2   (rf_rd2),
        .fwd_rd1  (fwd_rd1),
        .fwd_rd2  (fwd_rd2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rfile[i] <= 32'h0;
        end else if (rf_we) begin
            rfile[rf_a3] <= rf_wd;
        end
    end

    task automatic model_reset();
        refused = 0;
        m_we    = 1'b0;
        m_a3    = 5'd0;
        m_wd    = 32'h0;
        last_g0 = 1'b0;
        last_g1 = 1'b0;
    endtask

    // One clock cycle with the current inputs: compare at the negedge, advance
    // the model at the posedge, return at posedge+1.
    task automatic cycle();
        logic forced;
        logic e_s0r;
        logic e_s1r;
        logic e_st;
        @(negedge clk);
        forced = s1_valid && (refused == SM);
        e_s0r  = !forced;
        e_s1r  = forced || !s0_valid;
        e_st   = (refused == SM);
        n_cmp += 6;
        if (s0_ready !== e_s0r) begin
            n_err++;
            $display("FAIL s0_ready: got %b want %b at %0t", s0_ready, e_s0r, $time);
        end
        if (s1_ready !== e_s1r) begin
            n_err++;
            $display("FAIL s1_ready: got %b want %b at %0t", s1_ready, e_s1r, $time);
        end
        if (starve_o !== e_st) begin
            n_err++;
            $display("FAIL starve_o: got %b want %b at %0t", starve_o, e_st, $time);
        end
        if (rf_we !== m_we) begin
            n_err++;
            $display("FAIL rf_we: got %b want %b at %0t", rf_we, m_we, $time);
        end
        if (rf_a3 !== m_a3) begin
            n_err++;
            $display("FAIL rf_a3: got %0d want %0d at %0t", rf_a3, m_a3, $time);
        end
        if (rf_wd !== m_wd) begin
            n_err++;
            $display("FAIL rf_wd: got %h want %h at %0t", rf_wd, m_wd, $time);
        end
        last_g0 = s0_valid && e_s0r;
        last_g1 = s1_valid && e_s1r;
        @(posedge clk);
        if (last_g1 || !s1_valid) refused = 0;
        else refused = refused + 1;
        if (last_g0) begin
            m_we = (s0_rd != 5'd0);
            m_a3 = s0_rd;
            m_wd = s0_wd;
        end else if (last_g1) begin
            m_we = (s1_rd != 5'd0);
            m_a3 = s1_rd;
            m_wd = s1_wd;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        s0_rd    = 5'd0;
        s0_wd    = 32'h0;
        s1_rd    = 5'd0;
        s1_wd    = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 5;
        if (rf_we !== 1'b0 || rf_a3 !== 5'd0 || rf_wd !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got we=%b a3=%0d wd=%h want 0/0/0", rf_we, rf_a3, rf_wd);
        end
        if (starve_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_starve: got %b want 0", starve_o);
        end
        if (s0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_s0_ready: got %b want 1", s0_ready);
        end
        if (s1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_s1_ready: got %b want 1", s1_ready);
        end
        if (rfile[0] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rfile: got %h want 0", rfile[0]);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_port0();
        s0_valid = 1'b1;
        s0_rd    = 5'd1;
        s0_wd    = 32'd5;
        cycle();
        s0_valid = 1'b0;
        n_cmp += 2;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd1 || rf_wd !== 32'd5) begin
            n_err++;
            $display("FAIL port0_write: got we=%b a3=%0d wd=%0d want 1/1/5", rf_we, rf_a3, rf_wd);
        end
        cycle();
        if (rfile[1] !== 32'd5) begin
            n_err++;
            $display("FAIL port0_rfile_x1: got %0d want 5", rfile[1]);
        end
    endtask

    task automatic test_port1();
        s1_valid = 1'b1;
        s1_rd    = 5'd10;
        s1_wd    = 32'd123;
        cycle();
        s1_valid = 1'b0;
        n_cmp += 2;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd10 || rf_wd !== 32'd123) begin
            n_err++;
            $display("FAIL port1_write: got we=%b a3=%0d wd=%0d want 1/10/123", rf_we, rf_a3, rf_wd);
        end
        cycle();
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL port1_idle_we: got %b want 0", rf_we);
        end
    endtask

    task automatic test_x0();
        s0_valid = 1'b1;
        s0_rd    = 5'd0;
        s0_wd    = 32'd999;
        cycle();
        s0_valid = 1'b0;
        n_cmp += 2;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL x0_we: got %b want 0", rf_we);
        end
        cycle();
        if (rfile[0] !== 32'h0) begin
            n_err++;
            $display("FAIL x0_rfile: got %0d want 0", rfile[0]);
        end
    endtask

    task automatic test_starve();
        int n1;
        n1       = 0;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s0_rd    = 5'd3;
        s1_rd    = 5'd4;
        s0_wd    = $urandom;
        s1_wd    = $urandom;
        for (int i = 0; i < 15; i++) begin
            cycle();
            n_cmp += 2;
            if (last_g1 !== ((i % 5) == 4)) begin
                n_err++;
                $display("FAIL starve_pattern: cycle %0d got g1=%b want %b", i, last_g1,
                         (i % 5) == 4);
            end
            if ((last_g0 || last_g1) !== 1'b1) begin
                n_err++;
                $display("FAIL starve_no_grant: cycle %0d got 0 want 1", i);
            end
            if (last_g1) n1++;
            if (last_g0) s0_wd = $urandom;
            if (last_g1) s1_wd = $urandom;
        end
        n_cmp++;
        if (n1 != 3) begin
            n_err++;
            $display("FAIL starve_ratio: got %0d port-1 grants want 3", n1);
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        cycle();
    endtask

    task automatic test_async_reset();
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s0_rd    = 5'd6;
        s0_wd    = 32'h6666;
        s1_rd    = 5'd9;
        s1_wd    = 32'h9999;
        repeat (SM) cycle();
        // Now in PRI1 with port 0's write on rf_we; hit reset mid-cycle.
        #3;
        rst = 1'b1;
        #1;
        n_cmp += 2;
        if (rf_we !== 1'b0 || rf_a3 !== 5'd0 || rf_wd !== 32'h0) begin
            n_err++;
            $display("FAIL async_rst_outputs: got we=%b a3=%0d wd=%h want 0/0/0", rf_we, rf_a3,
                     rf_wd);
        end
        if (starve_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_starve: got %b want 0", starve_o);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst      = 1'b0;
        s0_valid = 1'b0;
        cycle();
        s1_valid = 1'b0;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd9 || rf_wd !== 32'h9999) begin
            n_err++;
            $display("FAIL async_rst_regrant: got we=%b a3=%0d wd=%h want 1/9/9999", rf_we, rf_a3,
                     rf_wd);
        end
        cycle();
    endtask

    task automatic test_random();
        logic p0;
        logic p1;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 99) < 55) begin
                p0    = 1'b1;
                s0_rd = 5'($urandom_range(0, 31));
                s0_wd = $urandom;
            end
            if (!p1 && $urandom_range(0, 99) < 70) begin
                p1    = 1'b1;
                s1_rd = 5'($urandom_range(0, 31));
                s1_wd = $urandom;
            end
            s0_valid = p0;
            s1_valid = p1;
            cycle();
            if (last_g0) p0 = 1'b0;
            if (last_g1) p1 = 1'b0;
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        cycle();
        cycle();
    endtask

`ifdef RF_WB_FWD_EN
    task automatic test_fwd();
        fwd_a1   = 5'd7;
        fwd_a2   = 5'd0;
        rf_rd1   = 32'h0;
        rf_rd2   = 32'h55;
        s0_valid = 1'b1;
        s0_rd    = 5'd7;
        s0_wd    = 32'hDEADBEEF;
        cycle();
        s0_valid = 1'b0;
        n_cmp += 2;
        if (fwd_rd1 !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL fwd_bypass: got %h want deadbeef", fwd_rd1);
        end
        if (fwd_rd2 !== 32'h55) begin
            n_err++;
            $display("FAIL fwd_a2_unrelated: got %h want 55", fwd_rd2);
        end
        cycle();
        rf_rd1 = 32'h1234;
        #1;
        n_cmp++;
        if (fwd_rd1 !== 32'h1234) begin
            n_err++;
            $display("FAIL fwd_follow: got %h want 1234", fwd_rd1);
        end
        s0_valid = 1'b1;
        s0_rd    = 5'd0;
        s0_wd    = 32'd77;
        cycle();
        s0_valid = 1'b0;
        n_cmp++;
        if (fwd_rd2 !== 32'h55) begin
            n_err++;
            $display("FAIL fwd_x0: got %h want 55", fwd_rd2);
        end
        cycle();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef RF_WB_FWD_EN
        fwd_a1 = 5'd0;
        fwd_a2 = 5'd0;
        rf_rd1 = 32'h0;
        rf_rd2 = 32'h0;
`endif
        test_reset();
        test_port0();
        test_port1();
        test_x0();
        test_starve();
        test_async_reset();
        test_random();
`ifdef RF_WB_FWD_EN
        test_fwd();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Backstop against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang want finish");
        $fatal(1);
    end

endmodule

// File: doc/rf_wb_arb.md
Name: rf_wb_arb

Overview:
- Write-port arbiter for the 32x32 RV32I register file, which has a single write port (a3/wd/we).
- Shares that port between two writeback sources: port 0 is the ALU, port 1 is the load/multicycle unit.
- Uses fixed priority to port 0, with a starvation counter that forces a port-1 grant after a bounded wait.
- Writes are registered, and the outputs drive the register file's a3/wd/we directly.

Parameters:
- REG_W, 5: register address width.
- DATA_W, 32: write data width.
- STARVE_MAX, 4: consecutive stalled cycles of port 1 before forced grant. Legal range ≥1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- s0_valid  in  1  ALU write request.
- s0_rd  in  REG_W  ALU destination register.
- s0_wd  in  DATA_W  ALU write data.
- s0_ready  out  1  ALU request accepted this cycle.
- s1_valid  in  1  load-unit write request.
- s1_rd  in  REG_W  load-unit destination register.
- s1_wd  in  DATA_W  load-unit write data.
- s1_ready  out  1  load-unit request accepted this cycle.
- rf_we  out  1  register file write enable.
- rf_a3  out  REG_W  register file write address.
- rf_wd  out  DATA_W  register file write data.
- starve_o  out  1  high while the FSM is in PRI1 (debug/perf).

Behaviour:
- Handshake:
  - A transfer occurs on a cycle where sN_valid && sN_ready, sampled at posedge.
  - Once asserted, valid, rd and wd stay stable until the handshake completes.
  - The arbiter never back-pressures both ports in the same cycle when either is valid.
- Ready, combinational:
  - PRI0: s0_ready=1; s1_ready=!s0_valid.
  - PRI1: s1_ready=1; s0_ready=!s1_valid.
- FSM states: PRI0 (reset state) and PRI1.
  - PRI0→PRI1 when s1_valid && !s1_ready && stall_cnt==STARVE_MAX-1.
  - PRI1→PRI0 on a port-1 handshake, or when s1_valid is low (request withdrawn; illegal, but must recover).
- stall_cnt, width $clog2(STARVE_MAX+1):
  - Increments each cycle that s1_valid && !s1_ready.
  - Clears on a port-1 handshake, on !s1_valid, and on entry to PRI1.
  - Saturates; never wraps.
- Output register:
  - On a handshake from port N: rf_a3<=sN_rd, rf_wd<=sN_wd, rf_we<=(sN_rd!=0).
  - With no handshake: rf_we<=0; rf_a3 and rf_wd hold.
- Latency:
  - Handshake at edge k drives rf_we during cycle k..k+1.
  - The register file commits the write at edge k+1, so a read of that register is valid after edge k+1.
- x0 writes: a request with rd=0 is accepted normally (ready and handshake occur) but produces rf_we=0. x0 must never be written.
- Simultaneous valid: exactly one port is granted per cycle, and the other is stalled with ready=0.
- Reset, asynchronous, any time including mid-request:
  - rf_we=0, rf_a3=0, rf_wd=0, state=PRI0, stall_cnt=0, starve_o=0.
  - A pending, unaccepted request is simply re-arbitrated after reset release.
  - A write registered before reset is discarded; rf_we goes to 0 immediately.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- With RF_WB_FWD_EN defined, the block adds these ports:
  - fwd_a1 in REG_W, fwd_a2 in REG_W.
  - rf_rd1 in DATA_W, rf_rd2 in DATA_W.
  - fwd_rd1 out DATA_W, fwd_rd2 out DATA_W.
- Forwarding rule, combinational: fwd_rdN = (rf_we && rf_a3==fwd_aN && fwd_aN!=0) ? rf_wd : rf_rdN. This gives the pending write to same-cycle readers.
- Without the macro, these ports and the bypass logic are absent, and readers see the write one cycle later.

Decomposition:
- Shared package rf_pkg:
  - REG_W, DATA_W, REG_S constants.
  - wb_req_t struct {rd, wd}.
  - arb_state_e enum {PRI0, PRI1}.
  - Also used by rfile and the pipeline writeback stage.
- One sub-module, rf_wb_prio_fsm, owns the FSM, stall_cnt and the ready generation. The top level holds the output register and the optional bypass.

Test Plan:
- Port 0 only, rd=1, wd=5:
  - s0_ready=1.
  - Next cycle rf_we=1, rf_a3=1, rf_wd=5.
  - The register file then reads x1=5.
- Port 1 only, rd=10, wd=123:
  - Accepted in the first cycle; rf_we=1, rf_a3=10, rf_wd=123.
  - A following cycle with no request gives rf_we=0.
- Port 0 writes rd=0, wd=999: handshake occurs, rf_we stays 0, and x0 reads 0.
- Both valid continuously, STARVE_MAX=4:
  - Port 0 wins 4 cycles, then port 1 is granted in cycle 5 with starve_o=1.
  - Then back to PRI0 with the pattern repeating; 4:1 grant ratio, no cycle without a grant.
- rst asserted asynchronously mid-cycle while rf_we=1 and in PRI1:
  - Outputs go to 0 immediately, before the next edge.
  - After release, the state is PRI0 and the held port-1 request is granted when port 0 is idle.
- RF_WB_FWD_EN:
  - Write x7=0xDEADBEEF while fwd_a1=7 and rf_rd1=0: fwd_rd1=0xDEADBEEF in the rf_we cycle, then follows rf_rd1.
  - With fwd_a2=0 and rf_a3=0, no bypass occurs.
